// File: rtl/simplerisc_pkg.sv
// SimpleRisc encoding constants shared by the encoder slice.
// Holds opcodes, immediate modifiers, field widths, the instruction
// word layout and the encoder FSM state type.
package simplerisc_pkg;

  localparam int unsigned OPC_W      = 5;
  localparam int unsigned REG_W      = 4;
  localparam int unsigned MOD_W      = 2;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned BR_OFS_W   = 27;
  localparam int unsigned BR_OFS_LSB = 2;
  localparam int unsigned WORD_W     = 32;

  localparam logic [OPC_W-1:0] OPC_MOV  = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_B    = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_BGT  = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_CALL = 5'b10011;

  localparam logic [MOD_W-1:0] MOD_SEXT = 2'b00;
  localparam logic [MOD_W-1:0] MOD_U    = 2'b01;
  localparam logic [MOD_W-1:0] MOD_H    = 2'b10;

  // Immediate-format word: [31:27] opc, [26] I, [25:22] rd, [21:18] rs1,
  // [17:16] modifier, [15:0] imm.
  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic             imm_flag;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [MOD_W-1:0] modifier;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT1 = 2'd1,
    ST_EMIT2 = 2'd2
  } enc_state_e;

  localparam logic [WORD_W-1:0] NOP_WORD = {OPC_NOP, 27'd0};

  function automatic logic is_branch_opc(input logic [OPC_W-1:0] opc);
    return (opc == OPC_B) || (opc == OPC_BEQ) ||
           (opc == OPC_BGT) || (opc == OPC_CALL);
  endfunction

endpackage

// File: rtl/imm_fit_select.sv
// Classifies a 32-bit constant into the cheapest mov encoding.
// Ports: value (constant in); mod_c/imm_c (first-word modifier and
// immediate); split_c (needs a second or.u word); unfit_c (cannot be
// encoded because splitting is disabled).
module imm_fit_select
  import simplerisc_pkg::*;
#(
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic [31:0]      value,
  output logic [MOD_W-1:0] mod_c,
  output logic [IMM_W-1:0] imm_c,
  output logic             split_c,
  output logic             unfit_c
);

  logic sext_fit;
  logic low_fit;
  logic high_fit;

  // Sign-extended fit: bits 31..15 all copies of one value.
  assign sext_fit = (&value[31:15]) | ~(|value[31:15]);
  assign low_fit  = ~(|value[31:16]);
  assign high_fit = ~(|value[15:0]);

  // First match wins; the split case reuses the mov.h upper half.
  always_comb begin
    mod_c   = MOD_H;
    imm_c   = value[31:16];
    split_c = 1'b0;
    unfit_c = 1'b0;
    if (sext_fit) begin
      mod_c = MOD_SEXT;
      imm_c = value[15:0];
    end else if (low_fit) begin
      mod_c = MOD_U;
      imm_c = value[15:0];
    end else if (high_fit) begin
      mod_c = MOD_H;
    end else if (ALLOW_SPLIT) begin
      split_c = 1'b1;
    end else begin
      unfit_c = 1'b1;
    end
  end

endmodule

// File: rtl/imm_btarget_encoder.sv
// Turns load-constant and branch requests into SimpleRisc words on a
// valid/ready stream tagged with the destination address.
// Ports: clk, rst_n; req_* request handshake and payload; out_* word
// stream (instr, pc, last, err). Optional IMM_ENC_STATS_EN adds
// stat_words / stat_errs handshake counters.
module imm_btarget_encoder
  import simplerisc_pkg::*;
#(
  parameter bit          ALLOW_SPLIT = 1'b1,
  parameter int unsigned PC_STEP     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_kind,
  input  logic [4:0]  req_opcode,
  input  logic [3:0]  req_rd,
  input  logic [31:0] req_value,
  input  logic [31:0] req_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_last,
  output logic        out_err
`ifdef IMM_ENC_STATS_EN
  ,
  output logic [15:0] stat_words,
  output logic [15:0] stat_errs
`endif
);

  enc_state_e  state_q, state_d;
  logic [31:0] w2_q, w2_d;
  logic        valid_d, last_d, err_d, ready_d;
  logic [31:0] instr_d, pc_d;

  logic [MOD_W-1:0] fit_mod;
  logic [IMM_W-1:0] fit_imm;
  logic             fit_split;
  logic             fit_unfit;

  logic [31:0] w1_c, w2_c;
  logic        two_c, err_c;
  logic [31:0] diff;
  logic        br_ok;
  instr_t      mov_word, or_word;

  imm_fit_select #(.ALLOW_SPLIT(ALLOW_SPLIT)) u_fit (
    .value   (req_value),
    .mod_c   (fit_mod),
    .imm_c   (fit_imm),
    .split_c (fit_split),
    .unfit_c (fit_unfit)
  );

  assign diff = req_value - req_pc;
  // Word-aligned offset whose bits 31..29 are pure sign extension of bit 28.
  assign br_ok = (diff[1:0] == 2'b00) && (diff[31:29] == {3{diff[28]}}) &&
                 is_branch_opc(req_opcode);

  // Encode both words of the incoming request.
  always_comb begin
    mov_word = '{opc: OPC_MOV, imm_flag: 1'b1, rd: req_rd, rs1: 4'd0,
                 modifier: fit_mod, imm: fit_imm};
    or_word  = '{opc: OPC_OR, imm_flag: 1'b1, rd: req_rd, rs1: req_rd,
                 modifier: MOD_U, imm: req_value[15:0]};
    w1_c  = NOP_WORD;
    w2_c  = 32'd0;
    two_c = 1'b0;
    err_c = 1'b0;
    if (!req_kind) begin
      if (fit_unfit) begin
        err_c = 1'b1;
      end else begin
        w1_c  = mov_word;
        w2_c  = or_word;
        two_c = fit_split;
      end
    end else if (br_ok) begin
      w1_c = {req_opcode, diff[BR_OFS_W+BR_OFS_LSB-1:BR_OFS_LSB]};
    end else begin
      err_c = 1'b1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    w2_d    = w2_q;
    valid_d = out_valid;
    instr_d = out_instr;
    pc_d    = out_pc;
    last_d  = out_last;
    err_d   = out_err;
    ready_d = req_ready;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = ST_EMIT1;
          w2_d    = w2_c;
          valid_d = 1'b1;
          instr_d = w1_c;
          pc_d    = req_pc;
          last_d  = ~two_c;
          err_d   = err_c;
          ready_d = 1'b0;
        end
      end
      ST_EMIT1: begin
        if (out_ready) begin
          // out_last clear on word 1 means a second word is pending.
          if (!out_last) begin
            state_d = ST_EMIT2;
            instr_d = w2_q;
            pc_d    = out_pc + 32'(PC_STEP);
            last_d  = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            err_d   = 1'b0;
            ready_d = 1'b1;
          end
        end
      end
      ST_EMIT2: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          err_d   = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      w2_q      <= 32'd0;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_pc    <= 32'd0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      w2_q      <= w2_d;
      out_valid <= valid_d;
      out_instr <= instr_d;
      out_pc    <= pc_d;
      out_last  <= last_d;
      out_err   <= err_d;
      req_ready <= ready_d;
    end
  end

`ifdef IMM_ENC_STATS_EN
  // Handshaken word and error-word counters, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words <= 16'd0;
      stat_errs  <= 16'd0;
    end else if (out_valid && out_ready) begin
      stat_words <= stat_words + 16'd1;
      if (out_err) begin
        stat_errs <= stat_errs + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_btarget_encoder.sv
// Directed bench for imm_btarget_encoder: dut_a splits constants,
// dut_b (ALLOW_SPLIT = 0) flags them as errors.
module tb_imm_btarget_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_a, req_valid_b;
  logic        req_ready_a, req_ready_b;
  logic        req_kind;
  logic [4:0]  req_opcode;
  logic [3:0]  req_rd;
  logic [31:0] req_value, req_pc;
  logic        out_ready;
  logic        out_valid_a, out_valid_b;
  logic [31:0] out_instr_a, out_instr_b, out_pc_a, out_pc_b;
  logic        out_last_a, out_last_b, out_err_a, out_err_b;
`ifdef IMM_ENC_STATS_EN
  logic [15:0] stat_words_a, stat_errs_a, stat_words_b, stat_errs_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_btarget_encoder #(.ALLOW_SPLIT(1'b1), .PC_STEP(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_kind(req_kind),
    .req_opcode(req_opcode), .req_rd(req_rd), .req_value(req_value),
    .req_pc(req_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_instr(out_instr_a), .out_pc(out_pc_a), .out_last(out_last_a),
    .out_err(out_err_a)
`ifdef IMM_ENC_STATS_EN
    , .stat_words(stat_words_a), .stat_errs(stat_errs_a)
`endif
  );

  imm_btarget_encoder #(.ALLOW_SPLIT(1'b0), .PC_STEP(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_kind(req_kind),
    .req_opcode(req_opcode), .req_rd(req_rd), .req_value(req_value),
    .req_pc(req_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_instr(out_instr_b), .out_pc(out_pc_b), .out_last(out_last_b),
    .out_err(out_err_b)
`ifdef IMM_ENC_STATS_EN
    , .stat_words(stat_words_b), .stat_errs(stat_errs_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present one request at a falling edge; it is accepted on the next rise.
  task automatic send(input bit to_b, input logic kind, input logic [4:0] opc,
                      input logic [3:0] rd, input logic [31:0] val, input logic [31:0] pc);
    req_kind   = kind;
    req_opcode = opc;
    req_rd     = rd;
    req_value  = val;
    req_pc     = pc;
    if (to_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    check("req_ready_idle", to_b ? req_ready_b : req_ready_a, 32'd1);
    @(negedge clk);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic look_word(input bit on_b, input string tag, input logic [31:0] instr,
                           input logic [31:0] pc, input logic last, input logic err);
    check({tag, ".valid"}, on_b ? out_valid_b : out_valid_a, 32'd1);
    check({tag, ".instr"}, on_b ? out_instr_b : out_instr_a, instr);
    check({tag, ".pc"},    on_b ? out_pc_b    : out_pc_a,    pc);
    check({tag, ".last"},  on_b ? out_last_b  : out_last_a,  32'(last));
    check({tag, ".err"},   on_b ? out_err_b   : out_err_a,   32'(err));
  endtask

  // Check the presented word, then let it handshake (out_ready high).
  task automatic expect_word(input bit on_b, input string tag, input logic [31:0] instr,
                             input logic [31:0] pc, input logic last, input logic err);
    look_word(on_b, tag, instr, pc, last, err);
    @(negedge clk);
  endtask

  task automatic expect_idle(input bit on_b, input string tag);
    check({tag, ".idle_valid"}, on_b ? out_valid_b : out_valid_a, 32'd0);
    check({tag, ".idle_ready"}, on_b ? req_ready_b : req_ready_a, 32'd1);
  endtask

  // Hold out_ready low for five cycles and require a frozen word.
  task automatic stall(input bit on_b, input string tag, input logic [31:0] instr,
                       input logic [31:0] pc, input logic last, input logic err);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      look_word(on_b, tag, instr, pc, last, err);
      check({tag, ".stall_ready"}, on_b ? req_ready_b : req_ready_a, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_kind    = 1'b0;
    req_opcode  = 5'd0;
    req_rd      = 4'd0;
    req_value   = 32'd0;
    req_pc      = 32'd0;
    out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.valid", out_valid_a, 32'd0);
    check("rst.instr", out_instr_a, 32'd0);
    check("rst.pc",    out_pc_a,    32'd0);
    check("rst.last",  out_last_a,  32'd0);
    check("rst.err",   out_err_a,   32'd0);
    check("rst.ready", req_ready_a, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-word constants on each modifier and at the fit boundaries.
    send(1'b0, 1'b0, 5'd0, 4'd3, 32'hFFFF8000, 32'h100);
    expect_word(1'b0, "c_sext", 32'h4CC08000, 32'h100, 1'b1, 1'b0);
    expect_idle(1'b0, "c_sext");
    send(1'b0, 1'b0, 5'd0, 4'd3, 32'h0000ABCD, 32'h200);
    expect_word(1'b0, "c_u", 32'h4CC1ABCD, 32'h200, 1'b1, 1'b0);
    send(1'b0, 1'b0, 5'd0, 4'd3, 32'h12340000, 32'h204);
    expect_word(1'b0, "c_h", 32'h4CC21234, 32'h204, 1'b1, 1'b0);
    send(1'b0, 1'b0, 5'd0, 4'd15, 32'h00007FFF, 32'h208);
    expect_word(1'b0, "c_maxpos", 32'h4FC07FFF, 32'h208, 1'b1, 1'b0);
    send(1'b0, 1'b0, 5'd0, 4'd3, 32'h00008000, 32'h20C);
    expect_word(1'b0, "c_u_edge", 32'h4CC18000, 32'h20C, 1'b1, 1'b0);
    send(1'b0, 1'b0, 5'd0, 4'd0, 32'h00000005, 32'h210);
    expect_word(1'b0, "c_small", 32'h4C000005, 32'h210, 1'b1, 1'b0);

    // Two-word constants.
    send(1'b0, 1'b0, 5'd0, 4'd3, 32'h12345678, 32'h100);
    expect_word(1'b0, "split.w1", 32'h4CC21234, 32'h100, 1'b0, 1'b0);
    expect_word(1'b0, "split.w2", 32'h3CCD5678, 32'h104, 1'b1, 1'b0);
    expect_idle(1'b0, "split");
    send(1'b0, 1'b0, 5'd0, 4'd3, 32'hFFFF7FFF, 32'h300);
    expect_word(1'b0, "split2.w1", 32'h4CC2FFFF, 32'h300, 1'b0, 1'b0);
    expect_word(1'b0, "split2.w2", 32'h3CCD7FFF, 32'h304, 1'b1, 1'b0);

    // Back-pressure in both emit states.
    send(1'b0, 1'b0, 5'd0, 4'd3, 32'h12345678, 32'h100);
    stall(1'b0, "hold.w1", 32'h4CC21234, 32'h100, 1'b0, 1'b0);
    @(negedge clk);
    stall(1'b0, "hold.w2", 32'h3CCD5678, 32'h104, 1'b1, 1'b0);
    @(negedge clk);
    expect_idle(1'b0, "hold");

    // Splitting disabled: nop with error, also under back-pressure.
    send(1'b1, 1'b0, 5'd0, 4'd3, 32'h12345678, 32'h100);
    stall(1'b1, "nosplit", 32'h68000000, 32'h100, 1'b1, 1'b1);
    @(negedge clk);
    expect_idle(1'b1, "nosplit");
    send(1'b1, 1'b0, 5'd0, 4'd3, 32'h0000ABCD, 32'h200);
    expect_word(1'b1, "nosplit_u", 32'h4CC1ABCD, 32'h200, 1'b1, 1'b0);

    // Branches.
    send(1'b0, 1'b1, 5'b10000, 4'd0, 32'h00000FF0, 32'h1000);
    expect_word(1'b0, "beq_back", 32'h87FFFFFC, 32'h1000, 1'b1, 1'b0);
    send(1'b0, 1'b1, 5'b10010, 4'd0, 32'h00000200, 32'h100);
    expect_word(1'b0, "b_fwd", 32'h90000040, 32'h100, 1'b1, 1'b0);
    send(1'b0, 1'b1, 5'b10011, 4'd0, 32'h0FFFFFFC, 32'h0);
    expect_word(1'b0, "call_maxfwd", 32'h9BFFFFFF, 32'h0, 1'b1, 1'b0);
    send(1'b0, 1'b1, 5'b10010, 4'd0, 32'h00000000, 32'h10000000);
    expect_word(1'b0, "b_maxback", 32'h94000000, 32'h10000000, 1'b1, 1'b0);
    send(1'b0, 1'b1, 5'b10000, 4'd0, 32'h00001002, 32'h1000);
    expect_word(1'b0, "br_misalign", 32'h68000000, 32'h1000, 1'b1, 1'b1);
    send(1'b0, 1'b1, 5'b10000, 4'd0, 32'h20001000, 32'h1000);
    expect_word(1'b0, "br_far", 32'h68000000, 32'h1000, 1'b1, 1'b1);
    send(1'b0, 1'b1, 5'b10001, 4'd0, 32'h10001000, 32'h1000);
    expect_word(1'b0, "br_far28", 32'h68000000, 32'h1000, 1'b1, 1'b1);
    send(1'b0, 1'b1, 5'b01001, 4'd0, 32'h00001004, 32'h1000);
    expect_word(1'b0, "br_badopc", 32'h68000000, 32'h1000, 1'b1, 1'b1);

`ifdef IMM_ENC_STATS_EN
    check("stat_words_b", 32'(stat_words_b), 32'd2);
    check("stat_errs_b",  32'(stat_errs_b),  32'd1);
`endif

    // Reset while word 2 is being presented.
    send(1'b0, 1'b0, 5'd0, 4'd3, 32'h12345678, 32'h400);
    expect_word(1'b0, "rstmid.w1", 32'h4CC21234, 32'h400, 1'b0, 1'b0);
    look_word(1'b0, "rstmid.w2", 32'h3CCD5678, 32'h404, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstmid.valid", out_valid_a, 32'd0);
    check("rstmid.ready", req_ready_a, 32'd1);
    check("rstmid.pc",    out_pc_a,    32'd0);
    check("rstmid.last",  out_last_a,  32'd0);
`ifdef IMM_ENC_STATS_EN
    check("rstmid.stat_words", 32'(stat_words_a), 32'd0);
    check("rstmid.stat_errs",  32'(stat_errs_a),  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle(1'b0, "after_rst");
    send(1'b0, 1'b0, 5'd0, 4'd3, 32'h12340000, 32'h500);
    expect_word(1'b0, "after_rst", 32'h4CC21234, 32'h500, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
